// File: rtl/chip_disp_pkg.sv
// Shared definitions for the chip dispenser actuator path: mode numbers,
// default bus width and the output-selector state encoding.
package chip_disp_pkg;

    localparam int unsigned MODE_NORMAL   = 0;
    localparam int unsigned MODE_MAINT    = 1;
    localparam int unsigned DEFAULT_WIDTH = 3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_BLANK = 2'd2
    } dispState_t;

endpackage

// File: rtl/mode_blank_counter.sv
// Down-counter timing the safe-value blanking window of a mode switch.
// Load has priority over decrement; the count saturates at zero.
module mode_blank_counter #(
    parameter int unsigned BLANK_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int unsigned CW = $clog2(BLANK_CYCLES) + 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(BLANK_CYCLES - 1);
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mode_output_selector.sv
// Registered N-way actuator source selector with break-before-make mode
// switching: drain the busy source, blank to a safe value, then switch.
module mode_output_selector
    import chip_disp_pkg::*;
#(
    parameter int unsigned      WIDTH        = DEFAULT_WIDTH,
    parameter int unsigned      NUM_MODES    = 4,
    parameter int unsigned      BLANK_CYCLES = 4,
    parameter logic [WIDTH-1:0] SAFE_VALUE   = '0,
    localparam int unsigned     SEL_W        = (NUM_MODES > 2) ? $clog2(NUM_MODES) : 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [SEL_W-1:0]           mode_req,
    input  logic                       mode_req_valid,
    input  logic                       busy,
    input  logic [NUM_MODES*WIDTH-1:0] src_data,
    output logic [WIDTH-1:0]           mux_out,
    output logic [SEL_W-1:0]           active_mode,
    output logic                       switching,
    output logic                       mode_ack,
    output logic                       mode_err
);

    localparam logic [SEL_W:0] NUM_MODES_W = (SEL_W + 1)'(NUM_MODES);

    dispState_t       state, stateNext;
    logic [SEL_W-1:0] pending, pendingNext, activeNext;
    logic             ackNext, errNext, errRaw, errHold, errHoldNext;
    logic             reqLegal, reqIllegal;
    logic             cntLoad, cntDec, cntZero;
    logic [WIDTH-1:0] selData;

    assign reqLegal   = mode_req_valid && ({1'b0, mode_req} < NUM_MODES_W);
    assign reqIllegal = mode_req_valid && !reqLegal;

    mode_blank_counter #(
        .BLANK_CYCLES(BLANK_CYCLES)
    ) uBlankCounter (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (cntLoad),
        .dec    (cntDec),
        .zero   (cntZero)
    );

    always_comb begin
        stateNext   = state;
        pendingNext = pending;
        activeNext  = active_mode;
        ackNext     = 1'b0;
        errRaw      = reqIllegal;
        cntLoad     = 1'b0;
        cntDec      = 1'b0;

        case (state)
            ST_RUN: begin
                if (reqLegal) begin
                    if (mode_req == active_mode) begin
                        ackNext = 1'b1;
                    end else begin
                        pendingNext = mode_req;
                        if (busy) begin
                            stateNext = ST_DRAIN;
                        end else begin
                            stateNext = ST_BLANK;
                            cntLoad   = 1'b1;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (reqLegal) pendingNext = mode_req;
                if (!busy) begin
                    stateNext = ST_BLANK;
                    cntLoad   = 1'b1;
                end
            end
            ST_BLANK: begin
                if (reqLegal) pendingNext = mode_req;
                if (cntZero) begin
                    stateNext  = ST_RUN;
                    activeNext = pendingNext;
                    ackNext    = 1'b1;
                end else begin
                    cntDec = 1'b1;
                end
            end
            default: stateNext = ST_RUN;
        endcase

        // An error colliding with an ack is carried to the next cycle so the
        // two pulses never overlap; back-to-back errors merge into one pulse.
        errNext     = errRaw || errHold;
        errHoldNext = 1'b0;
        if (ackNext && errNext) begin
            errNext     = 1'b0;
            errHoldNext = 1'b1;
        end
    end

    always_comb begin
        selData = SAFE_VALUE;
        for (int unsigned i = 0; i < NUM_MODES; i++) begin
            if (activeNext == SEL_W'(i)) selData = src_data[i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_RUN;
            active_mode <= SEL_W'(MODE_NORMAL);
            pending     <= SEL_W'(MODE_NORMAL);
            mux_out     <= SAFE_VALUE;
            switching   <= 1'b0;
            mode_ack    <= 1'b0;
            mode_err    <= 1'b0;
            errHold     <= 1'b0;
        end else begin
            state       <= stateNext;
            active_mode <= activeNext;
            pending     <= pendingNext;
            mux_out     <= (stateNext == ST_BLANK) ? SAFE_VALUE : selData;
            switching   <= (stateNext != ST_RUN);
            mode_ack    <= ackNext;
            mode_err    <= errNext;
            errHold     <= errHoldNext;
        end
    end

endmodule
